// File: rtl/acumulador_parcelas.sv
// Sequential six-term accumulator that drives the upstream mux select and sums the returned terms.
// Optional saturation of the final result to WIDTH bits is enabled with `define ACUMULADOR_SAT_EN.
module acumulador_parcelas #(
    parameter int WIDTH   = 16,
    parameter int N_TERMS = 6,
    parameter int SEL_W   = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
    input  logic [WIDTH-1:0]   parcela,
    output logic [SEL_W-1:0]   op,
    output logic [WIDTH+2:0]   soma,
    output logic               ocupado,
    output logic               pronto,
    output logic               overflow
);

    typedef enum logic [1:0] {
        INICIAL = 2'd0,
        SOMA    = 2'd1,
        FIM     = 2'd2
    } estado_t;

    localparam logic [SEL_W-1:0] ULTIMO_IDX = SEL_W'(N_TERMS - 1);

    estado_t           estado;
    estado_t           proximo;
    logic [SEL_W-1:0]  idx;
    logic              ultimo;
    logic [WIDTH+2:0]  soma_prox;

    assign ultimo    = (idx == ULTIMO_IDX);
    assign soma_prox = soma + {3'b000, parcela};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    // NOTE: every output of this block is defaulted first, so no path through the case infers a latch.
    always_comb begin
        proximo = estado;
        op      = '0;
        ocupado = 1'b0;
        pronto  = 1'b0;
        unique case (estado)
            INICIAL: begin
                if (iniciar) proximo = SOMA;
            end
            SOMA: begin
                op      = idx;
                ocupado = 1'b1;
                if (ultimo) proximo = FIM;
            end
            FIM: begin
                pronto  = 1'b1;
                proximo = INICIAL;
            end
            default: proximo = INICIAL;
        endcase
    end

`ifdef ACUMULADOR_SAT_EN
    localparam logic [WIDTH+2:0] SOMA_MAX = {3'b000, {WIDTH{1'b1}}};
    logic overflow_q;

    // The saturated value is written on the last addition so soma already holds it during FIM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            soma       <= '0;
            idx        <= '0;
            overflow_q <= 1'b0;
        end else begin
            unique case (estado)
                INICIAL: begin
                    if (iniciar) begin
                        soma       <= '0;
                        idx        <= '0;
                        overflow_q <= 1'b0;
                    end
                end
                SOMA: begin
                    idx <= idx + 1'b1;
                    if (ultimo && (soma_prox > SOMA_MAX)) begin
                        soma       <= SOMA_MAX;
                        overflow_q <= 1'b1;
                    end else begin
                        soma <= soma_prox;
                    end
                end
                default: ;
            endcase
        end
    end

    assign overflow = overflow_q;
`else
    // Full WIDTH+3-bit sum of N_TERMS terms can never wrap, so there is nothing to flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            soma <= '0;
            idx  <= '0;
        end else begin
            unique case (estado)
                INICIAL: begin
                    if (iniciar) begin
                        soma <= '0;
                        idx  <= '0;
                    end
                end
                SOMA: begin
                    idx  <= idx + 1'b1;
                    soma <= soma_prox;
                end
                default: ;
            endcase
        end
    end

    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_acumulador_parcelas.sv
// Directed bench for acumulador_parcelas; a behavioural mux returns termos[op] on parcela.
// Build with +define+ACUMULADOR_SAT_EN to check the saturating variant.
module tb_acumulador_parcelas;

    localparam int WIDTH = 16;

    logic              clock;
    logic              reset;
    logic              iniciar;
    logic [WIDTH-1:0]  parcela;
    logic [2:0]        op;
    logic [WIDTH+2:0]  soma;
    logic              ocupado;
    logic              pronto;
    logic              overflow;

    logic [WIDTH-1:0]  termos [8];
    int                passed;
    int                total;

    acumulador_parcelas #(.WIDTH(WIDTH), .N_TERMS(6), .SEL_W(3)) dut (
        .clock    (clock),
        .reset    (reset),
        .iniciar  (iniciar),
        .parcela  (parcela),
        .op       (op),
        .soma     (soma),
        .ocupado  (ocupado),
        .pronto   (pronto),
        .overflow (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Upstream mux: codes 6 and 7 return a poison value so a stray select corrupts the sum.
    assign parcela = termos[op];

    task automatic set_termos(input logic [WIDTH-1:0] a, b, c, d, e, f);
        termos[0] = a; termos[1] = b; termos[2] = c;
        termos[3] = d; termos[4] = e; termos[5] = f;
        termos[6] = 16'h7777; termos[7] = 16'h7777;
    endtask

    task automatic test_reset();
        reset = 1'b1; iniciar = 1'b0;
        set_termos(1, 2, 3, 4, 5, 6);
        #12;
        total++;
        if ({soma, op, ocupado, pronto, overflow} !== 25'd0)
            $display("FAIL reset_initial: soma=%0d op=%0d ocupado=%b pronto=%b overflow=%b, want all zero",
                     soma, op, ocupado, pronto, overflow);
        else passed++;
        @(negedge clock); reset = 1'b0;
        @(negedge clock);
        total++;
        if ({ocupado, pronto} !== 2'b00)
            $display("FAIL reset_idle: ocupado=%b pronto=%b, want 0 0", ocupado, pronto);
        else passed++;
    endtask

    // One pulse of iniciar, then the op sequence, pronto and final soma are checked cycle by cycle.
    task automatic run_checked(input string nome, input logic [WIDTH+2:0] soma_esp,
                               input logic ovf_esp, input bit busy_pulses);
        @(negedge clock); iniciar = 1'b1;
        @(negedge clock); iniciar = 1'b0;
        for (int k = 0; k < 6; k++) begin
            total++;
            if ({op, ocupado, pronto} !== {3'(k), 1'b1, 1'b0})
                $display("FAIL %s_step%0d: op=%0d ocupado=%b pronto=%b, want op=%0d ocupado=1 pronto=0",
                         nome, k, op, ocupado, pronto, k);
            else passed++;
            iniciar = (busy_pulses && k == 3);
            @(negedge clock);
        end
        total++;
        if ({pronto, ocupado, op} !== {1'b1, 1'b0, 3'd0} || soma !== soma_esp || overflow !== ovf_esp)
            $display("FAIL %s_fim: pronto=%b ocupado=%b op=%0d soma=%0d overflow=%b, want 1 0 0 %0d %b",
                     nome, pronto, ocupado, op, soma, overflow, soma_esp, ovf_esp);
        else passed++;
        iniciar = busy_pulses;
        @(negedge clock); iniciar = 1'b0;
        total++;
        if (pronto !== 1'b0 || ocupado !== 1'b0 || soma !== soma_esp || overflow !== ovf_esp)
            $display("FAIL %s_hold: pronto=%b ocupado=%b soma=%0d overflow=%b, want 0 0 %0d %b",
                     nome, pronto, ocupado, soma, overflow, soma_esp, ovf_esp);
        else passed++;
    endtask

    task automatic test_basic();
        set_termos(1, 2, 3, 4, 5, 6);
        run_checked("basic", 19'd21, 1'b0, 1'b0);
    endtask

    task automatic test_max();
        set_termos(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
`ifdef ACUMULADOR_SAT_EN
        run_checked("max", 19'h0FFFF, 1'b1, 1'b0);
`else
        run_checked("max", 19'd393210, 1'b0, 1'b0);
`endif
    endtask

    task automatic test_busy();
        set_termos(1, 2, 3, 4, 5, 6);
        run_checked("busy", 19'd21, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (ocupado !== 1'b0 || pronto !== 1'b0 || soma !== 19'd21)
                $display("FAIL busy_no_restart%0d: ocupado=%b pronto=%b soma=%0d, want 0 0 21",
                         k, ocupado, pronto, soma);
            else passed++;
            @(negedge clock);
        end
    endtask

    task automatic test_abort();
        int prontos;
        set_termos(1, 2, 3, 4, 5, 6);
        @(negedge clock); iniciar = 1'b1;
        @(negedge clock); iniciar = 1'b0;
        @(negedge clock);
        @(negedge clock);
        total++;
        if (op !== 3'd2 || soma !== 19'd3)
            $display("FAIL abort_pre: op=%0d soma=%0d, want 2 3", op, soma);
        else passed++;
        #2 reset = 1'b1;
        #1;
        total++;
        if ({soma, op, ocupado, pronto, overflow} !== 25'd0)
            $display("FAIL abort_async: soma=%0d op=%0d ocupado=%b pronto=%b overflow=%b, want all zero",
                     soma, op, ocupado, pronto, overflow);
        else passed++;
        @(negedge clock); reset = 1'b0;
        prontos = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (pronto === 1'b1 || ocupado === 1'b1) prontos++;
        end
        total++;
        if (prontos !== 0)
            $display("FAIL abort_no_pronto: active_cycles=%0d, want 0", prontos);
        else passed++;
        set_termos(10, 0, 0, 0, 0, 5);
        run_checked("abort_rerun", 19'd15, 1'b0, 1'b0);
    endtask

    task automatic test_continuous();
        int prontos;
        int bad_op;
        int ciclos [3];
        set_termos(1, 2, 3, 4, 5, 6);
        prontos = 0;
        bad_op  = 0;
        @(negedge clock); iniciar = 1'b1;
        for (int c = 0; c <= 26; c++) begin
            @(negedge clock);
            if (c == 19) iniciar = 1'b0;
            if (op > 3'd5) bad_op++;
            if (pronto === 1'b1) begin
                total++;
                if (soma !== 19'd21)
                    $display("FAIL cont_soma_c%0d: soma=%0d, want 21", c, soma);
                else passed++;
                if (prontos < 3) ciclos[prontos] = c;
                prontos++;
            end
        end
        total++;
        if (prontos !== 3 || ciclos[0] !== 6 || ciclos[1] !== 14 || ciclos[2] !== 22)
            $display("FAIL cont_cadence: count=%0d cycles=%0d,%0d,%0d, want 3 at 6,14,22",
                     prontos, ciclos[0], ciclos[1], ciclos[2]);
        else passed++;
        total++;
        if (bad_op !== 0)
            $display("FAIL cont_op_range: cycles_with_op_over_5=%0d, want 0", bad_op);
        else passed++;
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        iniciar = 1'b0;
        test_reset();
        test_basic();
        test_max();
        test_busy();
        test_abort();
        test_continuous();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
